// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram
//   Avalon-MM slave word memory with a fixed number of wait states per
//   transfer, plus a side-loading port for preloading program words.
//
//   Optional feature: define RANDOM_WAIT_EN to add 0..3 pseudo-random
//   extra stall cycles per transfer from an 8-bit LFSR.
//
//   Ports
//     clk          rising-edge clock
//     reset        synchronous, active-low reset
//     address      byte address; word index = address[log2(DEPTH)+1:2]
//     read         read request, held until waitrequest low
//     write        write request, held until waitrequest low
//     writedata    write data
//     byteenable   byte lane enables, bit n -> writedata[8n+7:8n]
//     waitrequest  1 = master must hold its request
//     readdata     registered read data, valid in DONE
//     inst_input   program-load enable
//     inst_addr    program-load byte address (word index = inst_addr[7:2])
//     instruction  program-load word
//
//   state | meaning
//   IDLE  | waiting for read/write
//   BUSY  | counting wait states; memory access on the last one
//   DONE  | waitrequest low for one cycle, transfer complete
module avalon_wait_ram #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic [4:0]     start_cnt;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  bus_idx;
    logic [AW-1:0]  load_idx;
    logic           request;
    logic           commit_write;

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:AW+2], address[1:0], inst_addr[1:0]};

    assign bus_idx  = address[AW+1:2];
    assign load_idx = AW'(inst_addr[7:2]);
    assign request  = read | write;

    assign waitrequest = (request | inst_input) && !(state == DONE && !inst_input);

`ifdef RANDOM_WAIT_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    // Fibonacci taps 8,6,5,4
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign start_cnt = 5'(WAIT_CYCLES) + 5'(lfsr[1:0]);
`else
    assign start_cnt = 5'(WAIT_CYCLES);
`endif

    // Write wins over read; a dropped request never reaches this point.
    assign commit_write = reset && !inst_input && state == BUSY && cnt == 5'd0 && write;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            readdata <= '0;
`ifdef RANDOM_WAIT_EN
            lfsr     <= 8'hA5;
`endif
        end else if (!inst_input) begin
            // A load cycle freezes the bus FSM entirely.
            case (state)
                IDLE: begin
                    if (request) begin
                        state <= BUSY;
                        cnt   <= start_cnt;
`ifdef RANDOM_WAIT_EN
                        lfsr  <= {lfsr[6:0], lfsr_fb};
`endif
                    end
                end
                BUSY: begin
                    if (!request) begin
                        state <= IDLE;
                    end else if (cnt != 5'd0) begin
                        cnt <= cnt - 5'd1;
                    end else begin
                        state <= DONE;
                        if (read && !write) begin
                            readdata <= mem[bus_idx];
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory contents survive reset; program loads are accepted at any time.
    always_ff @(posedge clk) begin
        if (inst_input) begin
            mem[load_idx] <= instruction;
        end else if (commit_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    mem[bus_idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

endmodule
